// File: rtl/add_accum_pkg.sv
// Shared types and constants for the add/accumulate unit.
// Optional saturation build: define ADD_ACCUM_SAT_EN.
`timescale 1ns/1ps

package add_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic MODE_PAIR = 1'b0;
    localparam logic MODE_ACC  = 1'b1;

    // One extra bit over WIDTH+CNT_W absorbs the carry of each a+b pair.
    function automatic int res_width(input int width, input int cnt_w);
        return width + cnt_w + 1;
    endfunction

endpackage

// File: rtl/add_ext_stage.sv
// Zero-extends both operands and the running total, then adds them.
// Purely combinational; RES_W is wide enough that no carry is lost.
`timescale 1ns/1ps

module add_ext_stage #(
    parameter int WIDTH = 8,
    parameter int RES_W = 13
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [RES_W-1:0] acc,
    output logic [RES_W-1:0] res
);

    assign res = acc + RES_W'(a) + RES_W'(b);

endmodule

// File: rtl/add_accum_unit.sv
// Sequential adder: pairwise a+b or burst accumulate over len beats.
// Define ADD_ACCUM_SAT_EN to add the sat port and clamp sum to WIDTH bits.
`timescale 1ns/1ps

module add_accum_unit
    import add_accum_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 4,
    localparam int RES_W = res_width(WIDTH, CNT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic [CNT_W-1:0] len,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ADD_ACCUM_SAT_EN
    output logic             sat,
`endif
    output logic [RES_W-1:0] sum
);

    state_t           state;
    logic [RES_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] len_q;

    logic             accept;
    logic [CNT_W-1:0] eff_len;
    logic [CNT_W-1:0] cnt_nxt;
    logic [RES_W-1:0] acc_in;
    logic [RES_W-1:0] add_res;
    logic [RES_W-1:0] res_out;
    logic             sat_nxt;

    assign accept  = in_valid && in_ready;
    assign eff_len = (len == '0) ? CNT_W'(1) : len;
    assign cnt_nxt = count + 1'b1;
    assign acc_in  = (state == IDLE) ? '0 : acc;

    add_ext_stage #(
        .WIDTH (WIDTH),
        .RES_W (RES_W)
    ) u_add (
        .a   (a),
        .b   (b),
        .acc (acc_in),
        .res (add_res)
    );

`ifdef ADD_ACCUM_SAT_EN
    localparam logic [RES_W-1:0] SAT_MAX = {{(RES_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};

    // Clamp the final total to the largest WIDTH-bit value.
    always_comb begin
        res_out = add_res;
        sat_nxt = 1'b0;
        if (add_res > SAT_MAX) begin
            res_out = SAT_MAX;
            sat_nxt = 1'b1;
        end
    end
`else
    assign res_out = add_res;
    assign sat_nxt = 1'b0;
`endif

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            len_q     <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
`ifdef ADD_ACCUM_SAT_EN
            sat       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        len_q <= eff_len;
                        acc   <= add_res;
                        if (mode == MODE_PAIR || eff_len == CNT_W'(1)) begin
                            state     <= OUT;
                            sum       <= res_out;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
`ifdef ADD_ACCUM_SAT_EN
                            sat       <= sat_nxt;
`endif
                        end else begin
                            state <= ACCUM;
                            count <= CNT_W'(1);
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc   <= add_res;
                        count <= cnt_nxt;
                        if (cnt_nxt == len_q) begin
                            state     <= OUT;
                            sum       <= res_out;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
`ifdef ADD_ACCUM_SAT_EN
                            sat       <= sat_nxt;
`endif
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        count     <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifndef ADD_ACCUM_SAT_EN
    logic unused_sat;
    assign unused_sat = sat_nxt;
`endif

endmodule

// File: tb/tb_add_accum_unit.sv
// Self-checking bench for add_accum_unit (randomized + directed).
// Expected values come from a plain-arithmetic model of the sum.
`timescale 1ns/1ps

module tb_add_accum_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int RES_W = WIDTH + CNT_W + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic [CNT_W-1:0] len;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] sum;
`ifdef ADD_ACCUM_SAT_EN
    logic             sat;
`endif

    int total = 0;
    int pass  = 0;

    add_accum_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ADD_ACCUM_SAT_EN
        .sat       (sat),
`endif
        .sum       (sum)
    );

    always #5 clk = ~clk;

    // Model: what the consumer should see for a given true total.
    function automatic logic [RES_W-1:0] exp_sum(input int t);
`ifdef ADD_ACCUM_SAT_EN
        return (t > 255) ? RES_W'(255) : RES_W'(t);
`else
        return RES_W'(t);
`endif
    endfunction

    function automatic int beats_of(input logic m, input logic [CNT_W-1:0] l);
        if (m == 1'b0) return 1;
        return (l == 0) ? 1 : int'(l);
    endfunction

    task automatic drive_beat(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                              input logic im, input logic [CNT_W-1:0] il);
        int n = 0;
        @(negedge clk);
        a = ia; b = ib; mode = im; len = il; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) $display("FAIL beat_accept in_ready=%b required 1", in_ready);
        else pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for the result, checks it, optionally holds off the consumer.
    task automatic collect(input string name, input int t, input int hold,
                           input bit strict, input bit xin);
        int n = 0;
        logic [RES_W-1:0] es;
        es = exp_sum(t);
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (out_valid !== 1'b1 || (strict && n != 0))
            $display("FAIL %s_latency out_valid=%b wait=%0d required 1/0", name, out_valid, n);
        else pass++;
        total++;
        if (sum !== es) $display("FAIL %s_sum got %0d required %0d", name, sum, es);
        else pass++;
`ifdef ADD_ACCUM_SAT_EN
        total++;
        if (sat !== (t > 255)) $display("FAIL %s_sat got %b required %b", name, sat, t > 255);
        else pass++;
`endif
        total++;
        if (in_ready !== 1'b0) $display("FAIL %s_in_ready got %b required 0", name, in_ready);
        else pass++;
        for (int i = 0; i < hold; i++) begin
            if (xin) begin
                in_valid = 1'b1; a = 'x; b = 'x;
            end
            @(negedge clk);
            total++;
            if (sum !== es || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL %s_hold sum=%0d ov=%b ir=%b required %0d/1/0",
                         name, sum, out_valid, in_ready, es);
            else pass++;
        end
        in_valid  = 1'b0;
        a = '0; b = '0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s_transfer ov=%b ir=%b required 0/1", name, out_valid, in_ready);
        else pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || sum !== '0)
            $display("FAIL reset_vals ir=%b ov=%b sum=%0d required 0/0/0", in_ready, out_valid, sum);
        else pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release in_ready=%b required 1", in_ready);
        else pass++;
    endtask

    task automatic test_pairwise();
        out_ready = 1'b1;
        drive_beat(8'd6, 8'd6, 1'b0, 4'd0);
        collect("pair_12", 12, 0, 1'b1, 1'b0);
        drive_beat(8'd6, 8'd7, 1'b0, 4'd5);
        collect("pair_13", 13, 0, 1'b1, 1'b0);
    endtask

    task automatic test_accum();
        drive_beat(8'd1, 8'd2, 1'b1, 4'd3);
        total++;
        if (out_valid !== 1'b0) $display("FAIL accum_early1 out_valid=%b required 0", out_valid);
        else pass++;
        drive_beat(8'd3, 8'd4, 1'b0, 4'd1);
        total++;
        if (out_valid !== 1'b0) $display("FAIL accum_early2 out_valid=%b required 0", out_valid);
        else pass++;
        drive_beat(8'd5, 8'd6, 1'b0, 4'd9);
        collect("accum_21", 21, 0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_beat(8'd200, 8'd100, 1'b0, 4'd0);
        collect("backpr_300", 300, 5, 1'b1, 1'b1);
    endtask

    task automatic test_max();
        int t = 0;
        for (int i = 0; i < 15; i++) begin
            drive_beat(8'd255, 8'd255, 1'b1, 4'd15);
            t += 510;
        end
        collect("max_7650", t, 0, 1'b1, 1'b0);
        drive_beat(8'd9, 8'd1, 1'b1, 4'd0);
        collect("len0_10", 10, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive_beat(8'd10, 8'd20, 1'b1, 4'd4);
        drive_beat(8'd30, 8'd40, 1'b1, 4'd4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b0)
            $display("FAIL rstmid_vals ov=%b sum=%0d ir=%b required 0/0/0", out_valid, sum, in_ready);
        else pass++;
        @(negedge clk);
        rst_n = 1'b1;
        drive_beat(8'd3, 8'd4, 1'b1, 4'd1);
        collect("rstmid_7", 7, 0, 1'b1, 1'b0);
    endtask

    task automatic test_sat();
        drive_beat(8'd255, 8'd1, 1'b0, 4'd0);
`ifdef ADD_ACCUM_SAT_EN
        total++;
        if (sum !== 13'd255 || sat !== 1'b1)
            $display("FAIL sat_255 sum=%0d sat=%b required 255/1", sum, sat);
        else pass++;
`else
        total++;
        if (sum !== 13'd256) $display("FAIL nosat_256 sum=%0d required 256", sum);
        else pass++;
`endif
        collect("sat_a", 256, 0, 1'b0, 1'b0);
        drive_beat(8'd100, 8'd27, 1'b0, 4'd0);
        collect("sat_b", 127, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic             m;
            logic [CNT_W-1:0] l;
            int               nb;
            int               t;
            int               hold;
            m    = 1'($urandom);
            l    = CNT_W'($urandom);
            nb   = beats_of(m, l);
            hold = int'($urandom_range(0, 3));
            t    = 0;
            out_ready = (hold == 0);
            for (int i = 0; i < nb; i++) begin
                logic [WIDTH-1:0] ra;
                logic [WIDTH-1:0] rb;
                ra = WIDTH'($urandom);
                rb = WIDTH'($urandom);
                t += int'(ra) + int'(rb);
                if (i == 0) drive_beat(ra, rb, m, l);
                else drive_beat(ra, rb, 1'($urandom), CNT_W'($urandom));
            end
            collect("rand", t, hold, 1'b1, 1'b0);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        mode      = 1'b0;
        len       = '0;
        out_ready = 1'b1;
        test_reset();
        test_pairwise();
        test_accum();
        test_backpressure();
        test_max();
        test_reset_mid();
        test_sat();
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
